// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the serial program loader.
// The frame format is: sync byte, 16-bit little-endian word count, 4N data bytes, XOR checksum byte.
package uart_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CNT_LO,
    CNT_HI,
    DATA,
    CHECK
  } state_t;

  localparam logic [7:0] SYNC_BYTE   = 8'hA5;
  localparam int         COUNT_WIDTH = 16;

endpackage

// File: rtl/uart_word_packer.sv
// Assembles four received bytes into one little-endian 32-bit word.
// word_valid is a combinational strobe that fires while the fourth byte is being presented.
module uart_word_packer (
  input  logic        i_Clock,
  input  logic        i_Reset_n,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word_data
);

  logic [1:0]  byte_idx;
  logic [23:0] lanes;

  // The top lane is never stored: it is the byte arriving with word_valid.
  assign word_valid = byte_valid && !clear && (byte_idx == 2'd3);
  assign word_data  = {byte_data, lanes};

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      byte_idx <= '0;
      lanes    <= '0;
    end else if (clear) begin
      byte_idx <= '0;
      lanes    <= '0;
    end else if (byte_valid) begin
      case (byte_idx)
        2'd0:    lanes[7:0]   <= byte_data;
        2'd1:    lanes[15:8]  <= byte_data;
        2'd2:    lanes[23:16] <= byte_data;
        default: ;
      endcase
      byte_idx <= byte_idx + 2'd1;
    end
  end

endmodule

// File: rtl/uart_boot_loader.sv
// Frame sequencer between the UART receiver and instruction memory: validates the frame,
// issues word writes at an auto-incrementing address and holds the CPU while loading.
module uart_boot_loader
  import uart_loader_pkg::*;
#(
  parameter int ADDR_WIDTH   = 10,
  parameter int BASE_ADDR    = 0,
  parameter int TIMEOUT_CLKS = 1000000
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset_n,
  input  logic                  i_Rx_DV,
  input  logic [7:0]            i_Rx_Byte,
  output logic                  o_Mem_We,
  output logic [ADDR_WIDTH-1:0] o_Mem_Addr,
  output logic [31:0]           o_Mem_Wdata,
  output logic                  o_Cpu_Hold,
  output logic                  o_Done,
  output logic                  o_Error
);

  localparam int              TO_W      = $clog2(TIMEOUT_CLKS + 1);
  localparam longint unsigned MEM_WORDS = 64'd1 << ADDR_WIDTH;

  state_t                  state, state_next;
  logic [7:0]              cnt_lo;
  logic [COUNT_WIDTH-1:0]  words_left;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [7:0]              checksum;
  logic [TO_W-1:0]         idle_cnt;
  logic [TO_W-1:0]         idle_cnt_inc;
  logic [COUNT_WIDTH-1:0]  frame_words;
  logic                    timeout_hit;
  logic                    count_bad;
  logic                    load_data;
  logic                    done_next;
  logic                    error_next;
  logic                    data_byte;
  logic                    word_valid;
  logic [31:0]             word_data;

  assign frame_words  = {i_Rx_Byte, cnt_lo};
  assign count_bad    = (frame_words == '0) || (64'(frame_words) > MEM_WORDS);
  assign data_byte    = i_Rx_DV && (state == DATA);
  assign idle_cnt_inc = idle_cnt + TO_W'(1);
  // The error is raised on the clock where the gap count would reach TIMEOUT_CLKS-1;
  // a byte arriving on that same clock wins.
  assign timeout_hit  = (state != IDLE) && !i_Rx_DV && (idle_cnt_inc == TO_W'(TIMEOUT_CLKS - 1));
  assign o_Cpu_Hold   = (state != IDLE);

  uart_word_packer u_packer (
    .i_Clock    (i_Clock),
    .i_Reset_n  (i_Reset_n),
    .clear      (state != DATA),
    .byte_valid (data_byte),
    .byte_data  (i_Rx_Byte),
    .word_valid (word_valid),
    .word_data  (word_data)
  );

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    load_data  = 1'b0;
    done_next  = 1'b0;
    error_next = 1'b0;
    case (state)
      IDLE: begin
        if (i_Rx_DV && (i_Rx_Byte == SYNC_BYTE)) state_next = CNT_LO;
      end
      CNT_LO: begin
        if (i_Rx_DV) state_next = CNT_HI;
      end
      CNT_HI: begin
        if (i_Rx_DV) begin
          if (count_bad) begin
            error_next = 1'b1;
            state_next = IDLE;
          end else begin
            load_data  = 1'b1;
            state_next = DATA;
          end
        end
      end
      DATA: begin
        if (word_valid && (words_left == COUNT_WIDTH'(1))) state_next = CHECK;
      end
      CHECK: begin
        if (i_Rx_DV) begin
          done_next  = (i_Rx_Byte == checksum);
          error_next = (i_Rx_Byte != checksum);
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (timeout_hit) begin
      error_next = 1'b1;
      state_next = IDLE;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state       <= IDLE;
      cnt_lo      <= '0;
      words_left  <= '0;
      addr        <= '0;
      checksum    <= '0;
      idle_cnt    <= '0;
      o_Mem_We    <= 1'b0;
      o_Mem_Addr  <= '0;
      o_Mem_Wdata <= '0;
      o_Done      <= 1'b0;
      o_Error     <= 1'b0;
    end else begin
      state    <= state_next;
      o_Done   <= done_next;
      o_Error  <= error_next;
      o_Mem_We <= 1'b0;

      if (i_Rx_DV || (state_next == IDLE)) idle_cnt <= '0;
      else                                  idle_cnt <= idle_cnt_inc;

      if (i_Rx_DV && (state == CNT_LO)) cnt_lo <= i_Rx_Byte;

      if (load_data) begin
        addr       <= ADDR_WIDTH'(BASE_ADDR);
        words_left <= frame_words;
        checksum   <= '0;
      end

      if (data_byte) begin
        checksum <= checksum ^ i_Rx_Byte;
        if (word_valid) begin
          o_Mem_We    <= 1'b1;
          o_Mem_Addr  <= addr;
          o_Mem_Wdata <= word_data;
          addr        <= addr + ADDR_WIDTH'(1);
          words_left  <= words_left - COUNT_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Scoreboard bench: two loader instances (wide memory at base 0, 4-word memory at base 3),
// both with a 16-clock byte timeout; expected writes/pulses are queued before stimulus.
module tb_uart_boot_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  rx_dv = '0;
  logic [7:0]  rx_byte = '0;

  logic        we_a, hold_a, done_a, err_a;
  logic [9:0]  addr_a;
  logic [31:0] wdata_a;
  logic        we_b, hold_b, done_b, err_b;
  logic [1:0]  addr_b;
  logic [31:0] wdata_b;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int last_dv_cyc = 0;
  int err_cyc_a = 0;

  typedef struct {
    int          dut;
    logic [9:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    int dut;
    bit is_done;
  } ev_t;

  wr_t wq[$];
  ev_t eq[$];

  uart_boot_loader #(.ADDR_WIDTH(10), .BASE_ADDR(0), .TIMEOUT_CLKS(16)) dut_a (
    .i_Clock(clk), .i_Reset_n(rst_n), .i_Rx_DV(rx_dv[0]), .i_Rx_Byte(rx_byte),
    .o_Mem_We(we_a), .o_Mem_Addr(addr_a), .o_Mem_Wdata(wdata_a),
    .o_Cpu_Hold(hold_a), .o_Done(done_a), .o_Error(err_a)
  );

  uart_boot_loader #(.ADDR_WIDTH(2), .BASE_ADDR(3), .TIMEOUT_CLKS(16)) dut_b (
    .i_Clock(clk), .i_Reset_n(rst_n), .i_Rx_DV(rx_dv[1]), .i_Rx_Byte(rx_byte),
    .o_Mem_We(we_b), .o_Mem_Addr(addr_b), .o_Mem_Wdata(wdata_b),
    .o_Cpu_Hold(hold_b), .o_Done(done_b), .o_Error(err_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_wr(input int d, input logic [9:0] a, input logic [31:0] w);
    wr_t e;
    e.dut = d; e.addr = a; e.data = w;
    wq.push_back(e);
  endtask

  task automatic push_ev(input int d, input bit is_done);
    ev_t e;
    e.dut = d; e.is_done = is_done;
    eq.push_back(e);
  endtask

  // Bytes are sent back-to-back, most significant byte of v first.
  task automatic send_frame(input int d, input logic [191:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      rx_dv[d] = 1'b1;
      rx_byte  = v[8*(n-1-i) +: 8];
      @(posedge clk);
      #1;
      last_dv_cyc = cyc;
    end
    rx_dv = '0;
  endtask

  task automatic idle_cycles(input int k);
    rx_dv = '0;
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input string name, input int budget);
    for (int i = 0; i < budget && (wq.size() != 0 || eq.size() != 0); i++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    check({name, "_writes_left"}, 64'(wq.size()), 64'd0);
    check({name, "_events_left"}, 64'(eq.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        logic        we, done, err, hold;
        logic [9:0]  a;
        logic [31:0] w;
        we   = (d == 0) ? we_a : we_b;
        done = (d == 0) ? done_a : done_b;
        err  = (d == 0) ? err_a : err_b;
        hold = (d == 0) ? hold_a : hold_b;
        a    = (d == 0) ? addr_a : {8'b0, addr_b};
        w    = (d == 0) ? wdata_a : wdata_b;
        if (we) begin
          if (wq.size() == 0) check("unexpected_write", 64'(we), 64'd0);
          else begin
            wr_t e;
            e = wq.pop_front();
            check("write_dut", 64'(d), 64'(e.dut));
            check("write_addr", 64'(a), 64'(e.addr));
            check("write_data", 64'(w), 64'(e.data));
          end
        end
        if (done || err) begin
          if (d == 0 && err) err_cyc_a = cyc;
          if (eq.size() == 0) check("unexpected_pulse", 64'({done, err}), 64'd0);
          else begin
            ev_t e;
            e = eq.pop_front();
            check("pulse_dut", 64'(d), 64'(e.dut));
            check("pulse_kind", 64'({done, err}), 64'({e.is_done, !e.is_done}));
            check("hold_falls_with_pulse", 64'(hold), 64'd0);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    check("rst_we_a", 64'(we_a), 64'd0);
    check("rst_hold_a", 64'(hold_a), 64'd0);
    check("rst_done_a", 64'(done_a), 64'd0);
    check("rst_err_a", 64'(err_a), 64'd0);
    check("rst_addr_a", 64'(addr_a), 64'd0);
    check("rst_wdata_a", 64'(wdata_a), 64'd0);
    check("rst_hold_b", 64'(hold_b), 64'd0);
    check("rst_we_b", 64'(we_b), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle_cycles(2);

    // Good frame, with hold observed after sync and mid-frame.
    push_wr(0, 10'd0, 32'h44332211);
    push_wr(0, 10'd1, 32'h88776655);
    push_ev(0, 1'b1);
    send_frame(0, {8'hA5}, 1);
    check("hold_after_sync", 64'(hold_a), 64'd1);
    send_frame(0, {8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88}, 10);
    check("hold_mid_frame", 64'(hold_a), 64'd1);
    send_frame(0, {8'h88}, 1);
    drain("good_frame", 20);
    check("hold_after_done", 64'(hold_a), 64'd0);

    // Bad checksum: writes still land, error instead of done.
    push_wr(0, 10'd0, 32'h44332211);
    push_wr(0, 10'd1, 32'h88776655);
    push_ev(0, 1'b0);
    send_frame(0, {8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
                   8'h55, 8'h66, 8'h77, 8'h88, 8'h00}, 12);
    drain("bad_checksum", 20);

    // Leading junk ignored, then zero count.
    send_frame(0, {8'h00, 8'hFF}, 2);
    check("hold_junk_ignored", 64'(hold_a), 64'd0);
    push_ev(0, 1'b0);
    send_frame(0, {8'hA5, 8'h00, 8'h00}, 3);
    drain("zero_count", 20);

    // Count 1025 exceeds a 1024-word memory.
    push_ev(0, 1'b0);
    send_frame(0, {8'hA5, 8'h01, 8'h04}, 3);
    drain("count_overflow_a", 20);

    // Four-word memory: count 5 rejected, count 4 accepted with address wrap.
    push_ev(1, 1'b0);
    send_frame(1, {8'hA5, 8'h05, 8'h00}, 3);
    drain("count_overflow_b", 20);
    push_wr(1, 10'd3, 32'h04030201);
    push_wr(1, 10'd0, 32'h08070605);
    push_wr(1, 10'd1, 32'h0C0B0A09);
    push_wr(1, 10'd2, 32'h100F0E0D);
    push_ev(1, 1'b1);
    send_frame(1, {8'hA5, 8'h04, 8'h00,
                   8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
                   8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h10, 8'h10}, 20);
    drain("wrap_frame", 20);

    // Stall after two data bytes: error 15 clocks after the last byte, no write.
    push_ev(0, 1'b0);
    err_cyc_a = 0;
    send_frame(0, {8'hA5, 8'h01, 8'h00, 8'hAA, 8'hBB}, 5);
    drain("timeout", 40);
    check("timeout_latency", 64'(err_cyc_a - last_dv_cyc), 64'd15);
    push_wr(0, 10'd0, 32'hEFBEADDE);
    push_ev(0, 1'b1);
    send_frame(0, {8'hA5, 8'h01, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22}, 8);
    drain("after_timeout", 20);

    // A byte landing on the terminal-count clock keeps the frame alive.
    push_wr(0, 10'd0, 32'h04030201);
    push_ev(0, 1'b1);
    send_frame(0, {8'hA5, 8'h01, 8'h00}, 3);
    idle_cycles(14);
    send_frame(0, {8'h01, 8'h02, 8'h03, 8'h04, 8'h04}, 5);
    drain("gap_at_limit", 40);

    // Reset after six data bytes: outputs drop at once, next frame restarts at base.
    push_wr(0, 10'd0, 32'h44332211);
    send_frame(0, {8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66}, 9);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_we", 64'(we_a), 64'd0);
    check("midrst_addr", 64'(addr_a), 64'd0);
    check("midrst_wdata", 64'(wdata_a), 64'd0);
    check("midrst_hold", 64'(hold_a), 64'd0);
    check("midrst_pulses", 64'({done_a, err_a}), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    drain("mid_reset", 20);
    push_wr(0, 10'd0, 32'hEFBEADDE);
    push_ev(0, 1'b1);
    send_frame(0, {8'hA5, 8'h01, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22}, 8);
    drain("after_reset", 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
